// File: rtl/id_ex_stage_pkg.sv
// Shared ID/EX definitions: control bundle layout, index widths, skid state encoding.
// Latency: n/a. Backpressure: n/a.
package id_ex_stage_pkg;

    localparam int CTRL_W     = 10;
    localparam int REG_IDX_W  = 5;

    localparam int ALU_SRC    = 0;
    localparam int REG_DST    = 1;
    localparam int BRANCH     = 2;
    localparam int MEM_RD     = 3;
    localparam int MEM_WR     = 4;
    localparam int REG_WR     = 5;
    localparam int ALU_OP_LSB = 6;
    localparam int ALU_OP_MSB = 8;
    localparam int SPARE      = 9;

    // Encoding is {skid_v, main_v}; 2'b10 cannot occur.
    typedef enum logic [1:0] {
        SKID_EMPTY = 2'b00,
        SKID_FULL1 = 2'b01,
        SKID_FULL2 = 2'b11
    } skid_state_t;

endpackage

// File: rtl/id_ex_stage_skid_buffer.sv
// Two-entry skid buffer with flush; MAIN drives the outputs, SKID absorbs one stall.
// Latency 1 cycle; in_rdy_o is !skid_v, registered, with no path from out_rdy_i.
module stage_skid_buffer
    import id_ex_stage_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         flush_i,
    input  logic         in_vld_i,
    output logic         in_rdy_o,
    input  logic [W-1:0] in_dat_i,
    output logic         out_vld_o,
    input  logic         out_rdy_i,
    output logic [W-1:0] out_dat_o
);

    skid_state_t  state_q;
    logic [W-1:0] main_q;
    logic [W-1:0] skid_q;

    // in_vld_i alone means accept in EMPTY/FULL1 since ready is high there.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= SKID_EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else if (flush_i) begin
            state_q <= SKID_EMPTY;
        end else begin
            case (state_q)
                SKID_EMPTY: begin
                    if (in_vld_i) begin
                        main_q  <= in_dat_i;
                        state_q <= SKID_FULL1;
                    end
                end
                SKID_FULL1: begin
                    if (in_vld_i && out_rdy_i) begin
                        main_q <= in_dat_i;
                    end else if (in_vld_i) begin
                        skid_q  <= in_dat_i;
                        state_q <= SKID_FULL2;
                    end else if (out_rdy_i) begin
                        state_q <= SKID_EMPTY;
                    end
                end
                SKID_FULL2: begin
                    if (out_rdy_i) begin
                        main_q  <= skid_q;
                        state_q <= SKID_FULL1;
                    end
                end
                default: state_q <= SKID_EMPTY;
            endcase
        end
    end

    assign in_rdy_o  = !state_q[1];
    assign out_vld_o = state_q[0];
    assign out_dat_o = main_q;

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX stage: computes operand B, branch target and write index, then registers them.
// Latency 1 cycle; stalls absorbed by a two-entry skid, ready_o is a register output.
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CTRL_W = id_ex_stage_pkg::CTRL_W
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 valid_i,
    output logic                 ready_o,
    input  logic                 flush_i,
    input  logic [DATA_W-1:0]    pc_plus4_i,
    input  logic [DATA_W-1:0]    rs_data_i,
    input  logic [DATA_W-1:0]    rt_data_i,
    input  logic [DATA_W-1:0]    imm_ext_i,
    input  logic [REG_IDX_W-1:0] rt_idx_i,
    input  logic [REG_IDX_W-1:0] rd_idx_i,
    input  logic [CTRL_W-1:0]    ctrl_i,
    output logic                 valid_o,
    input  logic                 ready_i,
    output logic [DATA_W-1:0]    rs_data_o,
    output logic [DATA_W-1:0]    alu_b_o,
    output logic [DATA_W-1:0]    rt_data_o,
    output logic [DATA_W-1:0]    branch_tgt_o,
    output logic [REG_IDX_W-1:0] wr_idx_o,
    output logic [CTRL_W-1:0]    ctrl_o
);

    localparam int PLD_W = 4 * DATA_W + REG_IDX_W + CTRL_W;

    logic [DATA_W-1:0]    alu_b;
    logic [DATA_W-1:0]    branch_tgt;
    logic [REG_IDX_W-1:0] wr_idx;
    logic [PLD_W-1:0]     pld_in;
    logic [PLD_W-1:0]     pld_out;

    // Word-offset shift drops the top two immediate bits; the sum wraps.
    assign branch_tgt = pc_plus4_i + {imm_ext_i[DATA_W-3:0], 2'b00};
    assign alu_b      = ctrl_i[ALU_SRC] ? imm_ext_i : rt_data_i;
    assign wr_idx     = ctrl_i[REG_DST] ? rd_idx_i : rt_idx_i;

    assign pld_in = {rs_data_i, alu_b, rt_data_i, branch_tgt, wr_idx, ctrl_i};
    assign {rs_data_o, alu_b_o, rt_data_o, branch_tgt_o, wr_idx_o, ctrl_o} = pld_out;

    stage_skid_buffer #(
        .W (PLD_W)
    ) u_skid (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .flush_i   (flush_i),
        .in_vld_i  (valid_i),
        .in_rdy_o  (ready_o),
        .in_dat_i  (pld_in),
        .out_vld_o (valid_o),
        .out_rdy_i (ready_i),
        .out_dat_o (pld_out)
    );

endmodule
